serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 80 ++++++++
 tb/tb_serial_addsub.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial 4-bit adder/subtractor, LSB first, with IDLE/RUN/DONE control.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module serial_addsub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [7:0] Y,
  output logic       busy,
`ifdef OVERFLOW_FLAG_EN
  output logic       ovf,
`endif
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state;
  logic [3:0] opa, opb, sum;
  logic [1:0] cnt;
  logic       mode, cy, fin, bb, sb, co;
`ifdef OVERFLOW_FLAG_EN
  logic       c3;
`endif
  assign bb = opb[0] ^ mode;
  assign sb = opa[0] ^ bb ^ cy;
  assign co = (opa[0] & bb) | (cy & (opa[0] ^ bb));
  // fin adds one cycle after bit 3 so the result lands five edges after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      sum   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      cy    <= 1'b0;
      fin   <= 1'b0;
      Y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      c3    <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != RUN && start) begin
        state <= RUN;
        busy  <= 1'b1;
        opa   <= A;
        opb   <= B;
        mode  <= M;
        cy    <= M;
        cnt   <= '0;
        fin   <= 1'b0;
      end else if (state == RUN && !fin) begin
        sum <= {sb, sum[3:1]};
        cy  <= co;
        opa <= opa >> 1;
        opb <= opb >> 1;
        cnt <= cnt + 2'd1;
        fin <= cnt == 2'd3;
`ifdef OVERFLOW_FLAG_EN
        if (cnt == 2'd2) c3 <= co;
`endif
      end else if (state == RUN) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        Y     <= {3'b000, cy ^ mode, sum};
`ifdef OVERFLOW_FLAG_EN
        ovf   <= c3 ^ cy;
`endif
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors for serial_addsub with hand-computed results.
module tb_serial_addsub;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic       M = 1'b0;
  logic [7:0] Y;
  logic       busy, done;
`ifdef OVERFLOW_FLAG_EN
  logic       ovf;
`endif
  int total = 0, bad = 0;

  serial_addsub dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
    .Y(Y), .busy(busy),
`ifdef OVERFLOW_FLAG_EN
    .ovf(ovf),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic m,
                        input logic [7:0] ey, input logic eo);
    @(negedge clk);
    A = a; B = b; M = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {7'd0, busy}, 8'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_early", {7'd0, done}, 8'd0);
    chk("busy_in_run", {7'd0, busy}, 8'd1);
    @(posedge clk); #1;
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("result", Y, ey);
    chk("busy_in_done", {7'd0, busy}, 8'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("ovf", {7'd0, ovf}, {7'd0, eo});
`else
    if (eo) chk("ovf_unused", 8'd0, 8'd0 & Y);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", {7'd0, done}, 8'd0);
    chk("y_hold", Y, ey);
  endtask

  initial begin
    #1;
    chk("rst_y", Y, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(4'hF, 4'h1, 1'b0, 8'h10, 1'b0);
    run_op(4'h5, 4'h3, 1'b1, 8'h02, 1'b0);
    run_op(4'h3, 4'h5, 1'b1, 8'h1E, 1'b0);
    run_op(4'h9, 4'h9, 1'b0, 8'h12, 1'b1);
    run_op(4'h0, 4'h0, 1'b1, 8'h00, 1'b0);
    run_op(4'h7, 4'h1, 1'b0, 8'h08, 1'b1);
    run_op(4'h8, 4'h1, 1'b1, 8'h07, 1'b1);
    run_op(4'h2, 4'h3, 1'b0, 8'h05, 1'b0);

    // start held through RUN with operands changing, then back-to-back from DONE
    @(negedge clk);
    A = 4'hF; B = 4'h1; M = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      A = 4'(i * 3); B = 4'(i + 7); M = i[0];
      @(posedge clk); #1;
      chk("held_no_done", {7'd0, done}, 8'd0);
    end
    @(posedge clk); #1;
    chk("held_done", {7'd0, done}, 8'd1);
    chk("held_result", Y, 8'h10);
    A = 4'h5; B = 4'h3; M = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {7'd0, busy}, 8'd1);
    chk("b2b_no_done", {7'd0, done}, 8'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_done", {7'd0, done}, 8'd1);
    chk("b2b_result", Y, 8'h02);
    @(posedge clk); #1;
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_done", {7'd0, done}, 8'd0);

    // reset in the third RUN cycle aborts the operation
    @(negedge clk);
    A = 4'h9; B = 4'h9; M = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_y", Y, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {7'd0, done}, 8'd0);
    end
    run_op(4'h2, 4'h2, 1'b0, 8'h04, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
